// File: rtl/mem_port_arbiter.sv
// Shared main-memory port arbiter between the instruction and data caches.
// One owner at a time; D wins ties but can only win MAX_D_STREAK times in a
// row while I is waiting. Memory strobes, addresses and the returned line are
// registered, and acks are routed only to the current owner.
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned LINE_WORDS   = 4,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_rd_req,
  input  logic                            d_rd_req,
  input  logic                            i_wr_req,
  input  logic                            d_wr_req,
  input  logic [WORD_SIZE-1:0]            i_rd_addr,
  input  logic [WORD_SIZE-1:0]            i_wr_addr,
  input  logic [WORD_SIZE-1:0]            d_rd_addr,
  input  logic [WORD_SIZE-1:0]            d_wr_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] i_wr_data,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wr_data,
  output logic                            i_rd_ack,
  output logic                            i_wr_ack,
  output logic                            d_rd_ack,
  output logic                            d_wr_ack,
  output logic [WORD_SIZE*LINE_WORDS-1:0] rd_data,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_rd_addr,
  output logic [WORD_SIZE-1:0]            mem_wr_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wr_data,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rd_data,
  input  logic                            mem_read_ack,
  input  logic                            mem_write_ack,
  output logic [1:0]                      owner
);

  localparam int unsigned LineW   = WORD_SIZE * LINE_WORDS;
  localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
  localparam logic [StreakW-1:0]   StreakMax = StreakW'(MAX_D_STREAK);
  // Clears the word-offset bits so addresses are line aligned.
  localparam logic [WORD_SIZE-1:0] AlignMask = ~WORD_SIZE'(3);
  localparam logic [1:0] OwnNone = 2'b00;
  localparam logic [1:0] OwnI    = 2'b01;
  localparam logic [1:0] OwnD    = 2'b10;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e               state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [StreakW-1:0]   streak_q, streak_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [WORD_SIZE-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic [WORD_SIZE-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [LineW-1:0]     mem_wr_data_q, mem_wr_data_d;
  logic [LineW-1:0]     rd_data_q, rd_data_d;
  logic                 i_rd_ack_q, i_rd_ack_d, i_wr_ack_q, i_wr_ack_d;
  logic                 d_rd_ack_q, d_rd_ack_d, d_wr_ack_q, d_wr_ack_d;

  logic                 i_pend, d_pend, grant_d, grant_i;
  logic                 g_wr_req;
  logic [WORD_SIZE-1:0] g_rd_addr, g_wr_addr;
  logic [LineW-1:0]     g_wr_data;
  logic                 own_is_d, own_rd_req;
  logic [WORD_SIZE-1:0] own_rd_addr;

  assign i_pend   = i_rd_req | i_wr_req;
  assign d_pend   = d_rd_req | d_wr_req;
  assign grant_d  = d_pend && (!i_pend || (streak_q < StreakMax));
  assign grant_i  = !grant_d && i_pend;

  // Request lines of the side being granted this cycle (IDLE only).
  assign g_wr_req  = grant_d ? d_wr_req  : i_wr_req;
  assign g_rd_addr = grant_d ? d_rd_addr : i_rd_addr;
  assign g_wr_addr = grant_d ? d_wr_addr : i_wr_addr;
  assign g_wr_data = grant_d ? d_wr_data : i_wr_data;

  // Request lines of the current owner (WRITE/READ).
  assign own_is_d    = (owner_q == OwnD);
  assign own_rd_req  = own_is_d ? d_rd_req  : i_rd_req;
  assign own_rd_addr = own_is_d ? d_rd_addr : i_rd_addr;

  // Next-state, grant and memory-strobe decisions.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    streak_d      = streak_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_rd_addr_d = mem_rd_addr_q;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rd_data_d     = rd_data_q;
    i_rd_ack_d    = 1'b0;
    i_wr_ack_d    = 1'b0;
    d_rd_ack_d    = 1'b0;
    d_wr_ack_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_d || grant_i) begin
          owner_d = grant_d ? OwnD : OwnI;
          if (grant_i) begin
            streak_d = '0;
          end else if (i_pend && (streak_q != StreakMax)) begin
            streak_d = streak_q + StreakW'(1);
          end
          // Eviction goes out before the fill.
          if (g_wr_req) begin
            state_d       = StWrite;
            mem_write_d   = 1'b1;
            mem_wr_addr_d = g_wr_addr & AlignMask;
            mem_wr_data_d = g_wr_data;
          end else begin
            state_d       = StRead;
            mem_read_d    = 1'b1;
            mem_rd_addr_d = g_rd_addr & AlignMask;
          end
        end
      end
      StWrite: begin
        if (mem_write_ack) begin
          mem_write_d = 1'b0;
          if (own_is_d) d_wr_ack_d = 1'b1;
          else          i_wr_ack_d = 1'b1;
          if (own_rd_req) begin
            state_d       = StRead;
            mem_read_d    = 1'b1;
            mem_rd_addr_d = own_rd_addr & AlignMask;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRead: begin
        if (mem_read_ack) begin
          mem_read_d = 1'b0;
          rd_data_d  = mem_rd_data;
          if (own_is_d) d_rd_ack_d = 1'b1;
          else          i_rd_ack_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
    endcase
  end

  // State and registered outputs; reset drops strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      owner_q       <= OwnNone;
      streak_q      <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      rd_data_q     <= '0;
      i_rd_ack_q    <= 1'b0;
      i_wr_ack_q    <= 1'b0;
      d_rd_ack_q    <= 1'b0;
      d_wr_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      streak_q      <= streak_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_data_q     <= rd_data_d;
      i_rd_ack_q    <= i_rd_ack_d;
      i_wr_ack_q    <= i_wr_ack_d;
      d_rd_ack_q    <= d_rd_ack_d;
      d_wr_ack_q    <= d_wr_ack_d;
    end
  end

  assign owner       = owner_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign rd_data     = rd_data_q;
  assign i_rd_ack    = i_rd_ack_q;
  assign i_wr_ack    = i_wr_ack_q;
  assign d_rd_ack    = d_rd_ack_q;
  assign d_wr_ack    = d_wr_ack_q;

endmodule
